// File: rtl/bcd2bin16_pkg.sv
// Shared types and constants for the 5-digit BCD to 16-bit binary converter.
package bcd2bin16_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned ITER    = 16;
  localparam int unsigned DIGITS  = 5;
  localparam int unsigned BIN_W   = 16;
  localparam int unsigned BCD_W   = 4 * DIGITS;
  localparam int unsigned WORK_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned MAX_VAL = 65535;

  localparam logic [3:0] MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd2bin16_nibble_adj.sv
// Per-digit correction after a right shift: values >= 8 lose 3 (4-bit modular).
module bcd_nibble_adj (
  input  logic [3:0] x_i,
  output logic [3:0] y_c_o
);

  assign y_c_o = (x_i >= 4'd8) ? (x_i - 4'd3) : x_i;

endmodule

// File: rtl/bcd2bin16.sv
// Serial BCD-to-binary converter (shift right, subtract 3), 16 shifts per result.
// Optional digit/overflow checking is enabled by defining BCD2BIN_CHECK_EN.
module bcd2bin16
  import bcd2bin16_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       bcd0,
  input  logic [3:0]       bcd1,
  input  logic [3:0]       bcd2,
  input  logic [3:0]       bcd3,
  input  logic [3:0]       bcd4,
  output logic             busy,
  output logic             done,
  output logic [BIN_W-1:0] bin,
  output logic             err
);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WORK_W-1:0] work_q;
  logic [WORK_W-1:0] work_d;
  logic [WORK_W-1:0] shifted_c;
  logic [BCD_W-1:0]  bcd_adj_c;
  logic [BIN_W-1:0]  bin_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              fin_err_c;
  logic              last_c;
  logic              accept_c;

  assign accept_c  = (state_q == IDLE) && start;
  assign shifted_c = {1'b0, work_q[WORK_W-1:1]};

  // Independent correction per BCD digit; no carry crosses digit boundaries.
  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_adj
    bcd_nibble_adj u_adj (
      .x_i   (shifted_c[BIN_W + 4*g +: 4]),
      .y_c_o (bcd_adj_c[4*g +: 4])
    );
  end

  assign work_d = {bcd_adj_c, shifted_c[BIN_W-1:0]};
  assign last_c = (cnt_q == CNT_W'(ITER - 1));

`ifdef BCD2BIN_CHECK_EN
  logic dig_err_q;
  logic load_err_c;

  assign load_err_c = (bcd0 > MAX_DIGIT) | (bcd1 > MAX_DIGIT) | (bcd2 > MAX_DIGIT) |
                      (bcd3 > MAX_DIGIT) | (bcd4 > MAX_DIGIT);

  // Invalid digits are only observable at load time, so remember them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_err_q <= 1'b0;
    end else if (accept_c) begin
      dig_err_q <= load_err_c;
    end
  end

  // A nonzero residual BCD field means the value exceeded MAX_VAL.
  assign fin_err_c = dig_err_q | (|work_d[WORK_W-1:BIN_W]);
`else
  assign fin_err_c = 1'b0;
`endif

  // Conversion FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      bin_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            work_q  <= {bcd4, bcd3, bcd2, bcd1, bcd0, BIN_W'(0)};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_c) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            bin_q   <= fin_err_c ? '0 : work_d[BIN_W-1:0];
            err_q   <= fin_err_c;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bin  = bin_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd2bin16.sv
// Scoreboard bench for bcd2bin16: stimulus pushes expected results, a monitor checks on done.
module tb_bcd2bin16;

`ifdef BCD2BIN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [15:0] bin;
    logic        err;
    bit          chk_bin;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  bcd0 = '0, bcd1 = '0, bcd2 = '0, bcd3 = '0, bcd4 = '0;
  logic        busy, done, err;
  logic [15:0] bin;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   last_acc = 0;
  bit   chk_rst = 1'b0;

  bcd2bin16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bcd0  (bcd0),
    .bcd1  (bcd1),
    .bcd2  (bcd2),
    .bcd3  (bcd3),
    .bcd4  (bcd4),
    .busy  (busy),
    .done  (done),
    .bin   (bin),
    .err   (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: all comparisons happen here, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_rst) begin
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_bin",  int'(bin),  0);
      check("rst_err",  int'(err),  0);
    end
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.chk_bin) check("bin", int'(bin), int'(mon_e.bin));
        check("err", int'(err), int'(mon_e.err));
        check("latency", cyc - mon_e.acc + 1, 17);
        check("busy_at_done", int'(busy), 1);
      end
    end else if (exp_q.size() != 0 && (cyc - exp_q[0].acc) > 20) begin
      check("done_timeout", 1, 0);
      void'(exp_q.pop_front());
    end
  end

  task automatic issue(input logic [3:0] d4, input logic [3:0] d3, input logic [3:0] d2,
                       input logic [3:0] d1, input logic [3:0] d0,
                       input logic [15:0] ebin, input logic eerr, input bit cb, input bit push);
    exp_t e;
    @(negedge clk);
    bcd4 = d4; bcd3 = d3; bcd2 = d2; bcd1 = d1; bcd0 = d0;
    start = 1'b1;
    last_acc = cyc + 1;
    if (push) begin
      e.bin = ebin; e.err = eerr; e.chk_bin = cb; e.acc = last_acc;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    chk_rst = 1'b1;
    @(negedge clk);
    #1 chk_rst = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed conversions
    issue(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b1); wait_idle();
    issue(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 16'h3039, 1'b0, 1'b1, 1'b1); wait_idle();
    issue(4'd6, 4'd5, 4'd5, 4'd3, 4'd5, 16'hFFFF, 1'b0, 1'b1, 1'b1); wait_idle();
    issue(4'd6, 4'd5, 4'd5, 4'd3, 4'd6, 16'h0000, CHK, 1'b1, 1'b1); wait_idle();
    issue(4'd9, 4'd9, 4'd9, 4'd9, 4'd9, CHK ? 16'h0000 : 16'h869F, CHK, 1'b1, 1'b1); wait_idle();
    issue(4'd0, 4'd0, 4'hA, 4'd0, 4'd0, 16'h0000, CHK, CHK, 1'b1); wait_idle();

    // Starts and digit changes during a conversion are ignored
    issue(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 16'h3039, 1'b0, 1'b1, 1'b1);
    while (cyc < last_acc + 4) @(negedge clk);
    bcd4 = 4'd0; bcd3 = 4'd0; bcd2 = 4'd0; bcd1 = 4'd4; bcd0 = 4'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < last_acc + 15) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    issue(4'd0, 4'd0, 4'd0, 4'd4, 4'd2, 16'h002A, 1'b0, 1'b1, 1'b1); wait_idle();

    // Reset mid-conversion aborts without a done pulse
    issue(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 16'h0000, 1'b0, 1'b0, 1'b0);
    while (cyc < last_acc + 7) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    chk_rst = 1'b1;
    @(negedge clk);
    #1 chk_rst = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue(4'd0, 4'd0, 4'd0, 4'd9, 4'd9, 16'h0063, 1'b0, 1'b1, 1'b1); wait_idle();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
